// File: rtl/cpu_flags_pkg.sv
// Shared flag-unit types and the helper that places pipeline registers
// between the levels of the zero-detect OR tree.
package cpu_flags_pkg;

    typedef struct packed {
        logic n;
        logic z;
        logic c;
        logic v;
    } nzcv_t;

    localparam nzcv_t FLAGS_RESET = 4'b0000;

    // True when a register stage sits right after tree level `level` (1-based).
    // The levels are cut into pipe+1 segments; earlier segments absorb the remainder.
    function automatic bit regAfterLevel(input int level, input int levels, input int pipe);
        int base;
        int extra;
        int boundary;
        bit hit;
        base     = levels / (pipe + 1);
        extra    = levels % (pipe + 1);
        boundary = 0;
        hit      = 1'b0;
        for (int s = 0; s < 2; s++) begin
            if (s < pipe) begin
                boundary = boundary + base + ((s < extra) ? 1 : 0);
                if (boundary == level) begin
                    hit = 1'b1;
                end
            end
        end
        return hit;
    endfunction

endpackage

// File: rtl/flag_unit_pipe_or_tree_level.sv
// One level of the zero-detect reduction: ORs adjacent bit pairs, halving the width.
module or_tree_level
    import cpu_flags_pkg::*;
#(
    parameter int IN_W = 2
) (
    input  logic [IN_W-1:0]   inBits,
    output logic [IN_W/2-1:0] orBits
);

    for (genvar gi = 0; gi < IN_W / 2; gi++) begin : gPair
        assign orBits[gi] = inBits[2*gi] | inBits[2*gi+1];
    end

endmodule

// File: rtl/flag_unit_pipe.sv
// NZCV flag unit: pipelined zero-detect tree with registered zero result
// and architectural flag register, supporting stall and flush.
module flag_unit_pipe
    import cpu_flags_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int PIPE  = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic             set_flags,
    input  logic             narrow,
    input  logic [WIDTH-1:0] result,
    input  logic             carry_in,
    input  logic             overflow_in,
    input  logic             stall,
    input  logic             flush,
    output logic             zero_valid,
    output logic             zero_out,
    output logic             flag_n,
    output logic             flag_z,
    output logic             flag_c,
    output logic             flag_v,
    output logic             busy
);

    localparam int LEVELS = $clog2(WIDTH);
    localparam int HALF   = WIDTH / 2;

    logic [WIDTH-1:0]  maskedResult;
    logic              resultSign;
    logic [LEVELS-1:0] stageValid;

    logic  tailValid;
    logic  tailSetFlags;
    logic  tailN;
    logic  tailC;
    logic  tailV;
    logic  tailZero;

    logic  zeroValidReg;
    logic  zeroOutReg;
    nzcv_t flagsReg;

    assign maskedResult = narrow ? {{HALF{1'b0}}, result[HALF-1:0]} : result;
    assign resultSign   = narrow ? result[HALF-1] : result[WIDTH-1];

    for (genvar gi = 0; gi < LEVELS; gi++) begin : gLevel
        localparam int IN_W    = WIDTH >> gi;
        localparam int OUT_W   = IN_W / 2;
        localparam bit HAS_REG = regAfterLevel(gi + 1, LEVELS, PIPE);

        logic [IN_W-1:0]  inBits;
        logic             inValid;
        logic             inSetFlags;
        logic             inN;
        logic             inC;
        logic             inV;
        logic [OUT_W-1:0] orBits;
        logic [OUT_W-1:0] outBits;
        logic             outValid;
        logic             outSetFlags;
        logic             outN;
        logic             outC;
        logic             outV;

        if (gi == 0) begin : gHead
            assign inBits     = maskedResult;
            assign inValid    = in_valid;
            assign inSetFlags = set_flags;
            assign inN        = resultSign;
            assign inC        = carry_in;
            assign inV        = overflow_in;
        end else begin : gChain
            assign inBits     = gLevel[gi-1].outBits;
            assign inValid    = gLevel[gi-1].outValid;
            assign inSetFlags = gLevel[gi-1].outSetFlags;
            assign inN        = gLevel[gi-1].outN;
            assign inC        = gLevel[gi-1].outC;
            assign inV        = gLevel[gi-1].outV;
        end

        or_tree_level #(
            .IN_W(IN_W)
        ) uLevel (
            .inBits(inBits),
            .orBits(orBits)
        );

        if (HAS_REG) begin : gReg
            // Only the valid bit needs clearing; payload is qualified by it.
            always_ff @(posedge clk) begin
                if (reset || flush) begin
                    outValid <= 1'b0;
                end else if (!stall) begin
                    outValid <= inValid;
                end
            end

            always_ff @(posedge clk) begin
                if (!stall) begin
                    outBits     <= orBits;
                    outSetFlags <= inSetFlags;
                    outN        <= inN;
                    outC        <= inC;
                    outV        <= inV;
                end
            end

            assign stageValid[gi] = outValid;
        end else begin : gWire
            assign outBits        = orBits;
            assign outValid       = inValid;
            assign outSetFlags    = inSetFlags;
            assign outN           = inN;
            assign outC           = inC;
            assign outV           = inV;
            assign stageValid[gi] = 1'b0;
        end
    end

    assign tailValid    = gLevel[LEVELS-1].outValid;
    assign tailSetFlags = gLevel[LEVELS-1].outSetFlags;
    assign tailN        = gLevel[LEVELS-1].outN;
    assign tailC        = gLevel[LEVELS-1].outC;
    assign tailV        = gLevel[LEVELS-1].outV;
    assign tailZero     = ~gLevel[LEVELS-1].outBits[0];

    // Retire stage: the zero pulse and the NZCV write share one edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            zeroValidReg <= 1'b0;
            zeroOutReg   <= 1'b0;
            flagsReg     <= FLAGS_RESET;
        end else begin
            zeroValidReg <= 1'b0;
            if (!flush && !stall && tailValid) begin
                zeroValidReg <= 1'b1;
                zeroOutReg   <= tailZero;
                if (tailSetFlags) begin
                    flagsReg <= '{n: tailN, z: tailZero, c: tailC, v: tailV};
                end
            end
        end
    end

    assign zero_valid = zeroValidReg;
    assign zero_out   = zeroOutReg;
    assign flag_n     = flagsReg.n;
    assign flag_z     = flagsReg.z;
    assign flag_c     = flagsReg.c;
    assign flag_v     = flagsReg.v;
    assign busy       = |stageValid;

endmodule

// File: tb/tb_flag_unit_pipe.sv
// Scoreboard bench for flag_unit_pipe: directed scenarios plus random traffic
// checked against a countdown model of in-flight entries.
module tb_flag_unit_pipe;

    localparam int WIDTH = 64;
    localparam int PIPE  = 2;
    localparam int HALF  = WIDTH / 2;

    logic             clk = 1'b0;
    logic             reset;
    logic             in_valid;
    logic             set_flags;
    logic             narrow;
    logic [WIDTH-1:0] result;
    logic             carry_in;
    logic             overflow_in;
    logic             stall;
    logic             flush;
    logic             zero_valid;
    logic             zero_out;
    logic             flag_n;
    logic             flag_z;
    logic             flag_c;
    logic             flag_v;
    logic             busy;

    flag_unit_pipe #(
        .WIDTH(WIDTH),
        .PIPE (PIPE)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .set_flags  (set_flags),
        .narrow     (narrow),
        .result     (result),
        .carry_in   (carry_in),
        .overflow_in(overflow_in),
        .stall      (stall),
        .flush      (flush),
        .zero_valid (zero_valid),
        .zero_out   (zero_out),
        .flag_n     (flag_n),
        .flag_z     (flag_z),
        .flag_c     (flag_c),
        .flag_v     (flag_v),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [WIDTH-1:0] res;
        bit               nr;
        bit               s;
        bit               c;
        bit               v;
        int               remaining;
    } entry_t;

    typedef struct {
        bit       zero;
        bit [3:0] nzcv;
    } expect_t;

    entry_t   inflight[$];
    expect_t  expQ[$];
    expect_t  monExp;
    bit [3:0] modelFlags = 4'b0000;
    bit       modelZero  = 1'b0;
    bit       modelBusy  = 1'b0;
    bit       started    = 1'b0;
    int       tests      = 0;
    int       failed     = 0;
    int       txCount    = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: an accepted entry needs PIPE more un-stalled edges to retire;
    // flush or reset throws away everything still counting down.
    task automatic modelEdge();
        entry_t  e;
        expect_t x;
        bit      sign;
        if (reset) begin
            inflight.delete();
            modelFlags = 4'b0000;
            modelZero  = 1'b0;
        end else if (flush) begin
            inflight.delete();
        end else if (!stall) begin
            if (in_valid) begin
                e.res       = result;
                e.nr        = narrow;
                e.s         = set_flags;
                e.c         = carry_in;
                e.v         = overflow_in;
                e.remaining = PIPE + 1;
                inflight.push_back(e);
            end
            foreach (inflight[i]) inflight[i].remaining--;
            if (inflight.size() > 0 && inflight[0].remaining == 0) begin
                e = inflight.pop_front();
                if (e.nr) begin
                    x.zero = (e.res[HALF-1:0] == '0);
                    sign   = e.res[HALF-1];
                end else begin
                    x.zero = (e.res == '0);
                    sign   = e.res[WIDTH-1];
                end
                if (e.s) modelFlags = {sign, x.zero, e.c, e.v};
                x.nzcv    = modelFlags;
                modelZero = x.zero;
                expQ.push_back(x);
            end
        end
        modelBusy = (inflight.size() > 0);
    endtask

    task automatic step(input bit iv, input bit s, input bit nr, input logic [WIDTH-1:0] r,
                        input bit c, input bit v, input bit st, input bit fl, input bit rs);
        in_valid    = iv;
        set_flags   = s;
        narrow      = nr;
        result      = r;
        carry_in    = c;
        overflow_in = v;
        stall       = st;
        flush       = fl;
        reset       = rs;
        @(posedge clk);
        modelEdge();
        started = 1'b1;
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, '0, 0, 0, 0, 0, 0);
    endtask

    always @(negedge clk) begin
        if (started) begin
            check("zero_valid", 32'(zero_valid), 32'(expQ.size() > 0));
            if (expQ.size() > 0) begin
                monExp = expQ.pop_front();
                check("zero_out", 32'(zero_out), 32'(monExp.zero));
                check("nzcv_update", 32'({flag_n, flag_z, flag_c, flag_v}), 32'(monExp.nzcv));
                txCount++;
                $display("[TB] tx %0d: zero_out=%b nzcv=%b (expected zero=%b nzcv=%b)",
                         txCount, zero_out, {flag_n, flag_z, flag_c, flag_v}, monExp.zero, monExp.nzcv);
            end else begin
                check("zero_hold", 32'(zero_out), 32'(modelZero));
            end
            check("nzcv", 32'({flag_n, flag_z, flag_c, flag_v}), 32'(modelFlags));
            check("busy", 32'(busy), 32'(modelBusy));
        end
    end

    initial begin
        logic [WIDTH-1:0] r;
        int               sel;
        in_valid = 0; set_flags = 0; narrow = 0; result = '0;
        carry_in = 0; overflow_in = 0; stall = 0; flush = 0; reset = 1;

        step(0, 0, 0, '0, 0, 0, 0, 0, 1);
        step(0, 0, 0, '0, 0, 0, 0, 0, 1);
        // First entry in the cycle reset drops: zero with S, C=1 -> NZCV 0110.
        step(1, 1, 0, '0, 1, 0, 0, 0, 0);
        idle(PIPE + 2);
        // Narrow masks the upper half; wide sees the set bit.
        step(1, 1, 1, 64'h0000_0001_0000_0000, 0, 0, 0, 0, 0);
        step(1, 1, 0, 64'h0000_0001_0000_0000, 0, 0, 0, 0, 0);
        idle(PIPE + 2);
        // Back to back: negative with S, then zero without S.
        step(1, 1, 0, 64'h8000_0000_0000_0000, 0, 0, 0, 0, 0);
        step(1, 0, 0, '0, 1, 1, 0, 0, 0);
        idle(PIPE + 2);
        // Stall three cycles mid-flight, in_valid ignored while stalled.
        step(1, 1, 0, '0, 0, 1, 0, 0, 0);
        idle(1);
        step(1, 1, 0, 64'h5, 1, 1, 1, 0, 0);
        step(0, 0, 0, '0, 0, 0, 1, 0, 0);
        step(0, 0, 0, '0, 0, 0, 1, 0, 0);
        idle(PIPE + 2);
        // Flush with an entry in stage 1, then flush together with stall.
        step(1, 1, 0, 64'h8000_0000_0000_0000, 1, 1, 0, 0, 0);
        step(1, 1, 0, '0, 0, 0, 0, 1, 0);
        idle(PIPE + 2);
        step(1, 1, 0, 64'h8000_0000_0000_0000, 1, 1, 0, 0, 0);
        step(1, 1, 0, '0, 0, 0, 1, 1, 0);
        idle(PIPE + 2);
        // Reset with two entries in flight.
        step(1, 1, 0, 64'h8000_0000_0000_0000, 1, 1, 0, 0, 0);
        step(1, 1, 0, '0, 1, 0, 0, 0, 0);
        step(1, 1, 0, '0, 1, 1, 1, 1, 1);
        idle(PIPE + 3);

        for (int k = 0; k < 800; k++) begin
            r   = {$urandom, $urandom};
            sel = $urandom_range(0, 4);
            if (sel == 0) r = '0;
            else if (sel == 1) r[HALF-1:0] = '0;
            else if (sel == 2) r[WIDTH-1:HALF] = '0;
            step($urandom_range(0, 9) < 7, $urandom_range(0, 1) == 1, $urandom_range(0, 3) == 0, r,
                 $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                 $urandom_range(0, 6) == 0, $urandom_range(0, 19) == 0, $urandom_range(0, 59) == 0);
        end
        idle(PIPE + 3);

        check("drain_pending", 32'(expQ.size() + inflight.size()), 32'(0));
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/flag_unit_pipe.md
FLAG_UNIT_PIPE -- requirements
Module: flag_unit_pipe

Interface
REQ-001 Parameter WIDTH, default 64, datapath width; SHALL be a power of two, 8..128.
REQ-002 Parameter PIPE, default 1, pipeline register stages inside the zero-detect tree; SHALL be 0, 1 or 2.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge only.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  result/carry/overflow valid this cycle.
REQ-006 set_flags  input  1  instruction writes NZCV (S-suffix); sampled with in_valid.
REQ-007 narrow  input  1  32-bit-style operation: use low WIDTH/2 bits only.
REQ-008 result  input  WIDTH  ALU result.
REQ-009 carry_in, overflow_in  input  1 each  ALU C and V.
REQ-010 stall  input  1  hold all pipeline stages.
REQ-011 flush  input  1  kill all in-flight entries.
REQ-012 zero_valid  output  1  one-cycle pulse: zero_out valid for one accepted result.
REQ-013 zero_out  output  1  result (or low half if narrow) is all zeros; for CBZ/CBNZ.
REQ-014 flag_n, flag_z, flag_c, flag_v  output  1 each  architectural NZCV register.
REQ-015 busy  output  1  any pipeline stage holds a valid entry.

Function
REQ-016 Zero detection SHALL be a balanced two-input OR reduction of log2(WIDTH) levels followed by inversion; in narrow mode the upper WIDTH/2 bits SHALL be masked to 0 before level 1.
REQ-017 N SHALL be result[WIDTH-1], or result[WIDTH/2-1] when narrow; C and V SHALL pass through unchanged.
REQ-018 PIPE registers SHALL split the tree levels as evenly as possible (earlier segments take the extra level); each stage carries valid, set_flags, N, C, V alongside partial ORs.
REQ-019 Latency: entry accepted (in_valid=1, stall=0) at edge t SHALL produce zero_valid/zero_out in the cycle after edge t+PIPE; with PIPE=0, zero_valid is asserted in the cycle following acceptance.
REQ-020 NZCV SHALL update at the same edge that raises zero_valid, only if the entry's set_flags=1; otherwise NZCV holds.
REQ-021 Throughput SHALL be one entry per cycle; back-to-back entries SHALL update flags in order, each visible for at least one cycle.
REQ-022 stall=1: no stage advances, in_valid ignored, zero_valid=0, NZCV holds.
REQ-023 flush=1: all stage valid bits cleared at the edge; NZCV and any update completing at that edge SHALL be suppressed; in_valid that cycle is dropped.
REQ-024 flush and stall together: flush SHALL win.
REQ-025 busy SHALL be the OR of all stage valid bits; with PIPE=0, busy=0 constantly.
REQ-026 zero_out SHALL hold its last value when zero_valid=0.

Reset
REQ-027 reset SHALL clear all stage valid bits, zero_valid=0, zero_out=0, busy=0, flag_n=flag_z=flag_c=flag_v=0.
REQ-028 Reset mid-operation SHALL discard in-flight entries with no flag update; reset SHALL dominate flush, stall and in_valid.
REQ-029 First entry may be accepted in the cycle reset deasserts.

Structure
REQ-030 Shared package cpu_flags_pkg SHALL hold typedef struct nzcv_t {n,z,c,v}, constant FLAGS_RESET = 4'b0000, and function for per-level register-boundary placement.
REQ-031 One sub-module or_tree_level SHALL implement one reduction level (parametrised input width IN_W, output IN_W/2); flag_unit_pipe instantiates log2(WIDTH) of them.
REQ-032 No latches; no combinational path from inputs to NZCV outputs.

Verification
REQ-033 WIDTH=64, PIPE=1: result=0, set_flags=1, C=1, V=0 -> two cycles later zero_out=1, NZCV=0110.
REQ-034 result=64'h0000_0001_0000_0000, narrow=1, set_flags=1 -> zero_out=1, Z=1, N=0; same with narrow=0 -> zero_out=0, Z=0.
REQ-035 Back-to-back: 64'h8000_0000_0000_0000 (S) then 64'h0 (no S) -> NZCV=1000 after first, held after second; zero_out pulses 0 then 1.
REQ-036 PIPE=2: accept 0 with S, stall 3 cycles mid-flight -> flag update delayed exactly 3 cycles, busy=1 throughout.
REQ-037 Flush with entry in stage 1, and flush+stall same cycle -> no zero_valid, NZCV unchanged, busy=0 next cycle.
REQ-038 Reset asserted with two entries in flight (PIPE=2) -> all outputs 0 next cycle, no later zero_valid.
